// File: rtl/audio_system_key_pkg.sv
// Shared constants for the push-button event controller: register map and reset values.
package audio_system_key_pkg;

   localparam logic [1:0] KEY_ADDR_DATA    = 2'd0;
   localparam logic [1:0] KEY_ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] KEY_ADDR_EDGECAP = 2'd2;
   localparam logic [1:0] KEY_ADDR_RAW     = 2'd3;

   localparam logic [31:0] KEY_READDATA_RST = 32'h0000_0000;
   localparam logic        KEY_IRQ_RST      = 1'b0;

endpackage

// File: rtl/audio_system_key_debounce.sv
// One key: 2-flop synchroniser, polarity normalisation (pressed = 1) and a
// consecutive-stable-cycle debounce counter.
module audio_system_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic raw,
   output logic stable
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic             IDLE    = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_pin;
   logic [CNT_W-1:0] cnt;

   // Synchroniser resets to the released pin level so reset never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= IDLE;
         sync_pin  <= IDLE;
      end else begin
         sync_meta <= pin;
         sync_pin  <= sync_meta;
      end
   end

   assign raw = ACTIVE_LOW ? ~sync_pin : sync_pin;

   // Counter only runs while raw disagrees with stable, and is cleared on acceptance, so it never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (raw == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         stable <= raw;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/audio_system_key_event_ctrl.sv
// Avalon-MM push-button controller: debounced levels, sticky press capture (W1C),
// per-key interrupt mask and a registered level IRQ.
module audio_system_key_event_ctrl
   import audio_system_key_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_mux;
   logic             wr_en;
   logic             rd_en;

   for (genvar k = 0; k < WIDTH; k++) begin : g_key
      audio_system_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .pin     (in_port[k]),
         .raw     (raw[k]),
         .stable  (stable[k])
      );
   end

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect & read;
   assign rise  = stable & ~stable_d;

   always_comb begin
      clr    = '0;
      rd_mux = '0;
      if (wr_en && address == KEY_ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
      case (address)
         KEY_ADDR_DATA:    rd_mux = stable;
         KEY_ADDR_IRQMASK: rd_mux = irq_mask;
         KEY_ADDR_EDGECAP: rd_mux = edge_cap;
         KEY_ADDR_RAW:     rd_mux = raw;
         default:          rd_mux = '0;
      endcase
   end

   // A new press on the same edge as its W1C clear survives: set wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d <= '0;
         edge_cap <= '0;
         irq_mask <= '0;
         irq      <= KEY_IRQ_RST;
         readdata <= KEY_READDATA_RST;
      end else begin
         stable_d <= stable;
         edge_cap <= (edge_cap & ~clr) | rise;
         irq      <= |(edge_cap & irq_mask);
         if (wr_en && address == KEY_ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
         if (rd_en) readdata <= 32'(rd_mux);
      end
   end

endmodule

// File: tb/tb_audio_system_key_event_ctrl.sv
// Bench for audio_system_key_event_ctrl with DEBOUNCE_CYCLES=8, active-low keys.
module tb_audio_system_key_event_ctrl;
   import audio_system_key_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEB   = 8;

   logic             clk;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             read;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   logic [31:0] exp_q[$];
   int          n_tests;
   int          n_fail;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[9];

   audio_system_key_event_ctrl #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string nm);
      chipselect = 1'b1; read = 1'b1; address = a;
      exp_q.push_back(e);
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      check(nm, readdata, exp_q.pop_front());
   endtask

   // Reads DATA every cycle starting at the edge after a pin change; the
   // debounced level appears after edge 2+DEB, so the read at edge 3+DEB shows it.
   task automatic data_trace(input int n, input logic [31:0] val, input string nm);
      chipselect = 1'b1; read = 1'b1; address = KEY_ADDR_DATA;
      for (int k = 1; k <= n; k++) begin
         exp_q.push_back((k >= DEB + 3) ? val : 32'h0);
         @(posedge clk); #1;
         check($sformatf("%s_c%0d", nm, k), readdata, exp_q.pop_front());
      end
      chipselect = 1'b0; read = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0;
      write_n = 1'b1; writedata = '0; in_port = 4'hF;

      // reset state
      idle(3);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset_n = 1'b1;
      do_read(KEY_ADDR_DATA, 32'h0, "rst_data");
      do_read(KEY_ADDR_EDGECAP, 32'h0, "rst_edgecap");

      // key0 press, cycle-exact DATA latency
      in_port = 4'hE;
      data_trace(14, 32'h1, "key0_data");
      do_read(KEY_ADDR_EDGECAP, 32'h1, "key0_edgecap");
      check("key0_irq_masked", {31'h0, irq}, 32'h0);

      // release key0: no event, DATA returns to 0
      in_port = 4'hF;
      idle(20);
      do_read(KEY_ADDR_DATA, 32'h0, "key0_release_data");

      // key1 glitch shorter than the debounce window
      in_port = 4'hD;
      idle(3);
      do_read(KEY_ADDR_RAW, 32'h2, "glitch_raw");
      idle(1);
      in_port = 4'hF;
      idle(20);
      do_read(KEY_ADDR_DATA, 32'h0, "glitch_data");
      do_read(KEY_ADDR_EDGECAP, 32'h1, "glitch_edgecap");

      // register access table
      vecs[0] = '{1'b1, KEY_ADDR_IRQMASK, 32'h0000_0001, 32'h0, "wr_mask"};
      vecs[1] = '{1'b0, KEY_ADDR_IRQMASK, 32'h0,         32'h1, "rd_mask"};
      vecs[2] = '{1'b1, KEY_ADDR_DATA,    32'h0000_000F, 32'h0, "wr_data_ign"};
      vecs[3] = '{1'b0, KEY_ADDR_DATA,    32'h0,         32'h0, "rd_data_ign"};
      vecs[4] = '{1'b1, KEY_ADDR_RAW,     32'h0000_000F, 32'h0, "wr_raw_ign"};
      vecs[5] = '{1'b0, KEY_ADDR_RAW,     32'h0,         32'h0, "rd_raw_ign"};
      vecs[6] = '{1'b1, KEY_ADDR_IRQMASK, 32'hFFFF_FFF1, 32'h0, "wr_mask_wide"};
      vecs[7] = '{1'b0, KEY_ADDR_IRQMASK, 32'h0,         32'h1, "rd_mask_wide"};
      vecs[8] = '{1'b0, KEY_ADDR_EDGECAP, 32'h0,         32'h1, "rd_edgecap"};
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
         else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
      check("mask_irq_on", {31'h0, irq}, 32'h1);

      // W1C clear: irq drops one cycle after the write edge
      do_write(KEY_ADDR_EDGECAP, 32'h1);
      check("w1c_irq_hold", {31'h0, irq}, 32'h1);
      idle(1);
      check("w1c_irq_off", {31'h0, irq}, 32'h0);
      do_read(KEY_ADDR_EDGECAP, 32'h0, "w1c_edgecap");

      // W1C of bit2 on the edge its press is captured: set wins
      in_port = 4'hB;
      idle(DEB + 2);
      do_write(KEY_ADDR_EDGECAP, 32'h4);
      do_read(KEY_ADDR_EDGECAP, 32'h4, "collide_edgecap");
      check("collide_irq", {31'h0, irq}, 32'h0);
      in_port = 4'hF;
      idle(20);
      do_write(KEY_ADDR_EDGECAP, 32'hF);
      do_read(KEY_ADDR_EDGECAP, 32'h0, "clear_all");

      // simultaneous presses
      in_port = 4'hC;
      idle(20);
      do_read(KEY_ADDR_DATA, 32'h3, "multi_data");
      do_read(KEY_ADDR_EDGECAP, 32'h3, "multi_edgecap");
      check("multi_irq", {31'h0, irq}, 32'h1);
      in_port = 4'hF;
      idle(20);

      // key3 held through reset
      in_port = 4'h7;
      idle(4);
      reset_n = 1'b0;
      idle(3);
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_irq", {31'h0, irq}, 32'h0);
      reset_n = 1'b1;
      data_trace(13, 32'h8, "key3_data");
      do_read(KEY_ADDR_EDGECAP, 32'h8, "key3_edgecap");
      do_read(KEY_ADDR_IRQMASK, 32'h0, "key3_mask");
      check("key3_irq", {31'h0, irq}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
